serial_adder: RTL
=================

Name: serial_adder

Overview:
Bit-serial WIDTH-bit adder built around a single one-bit full-adder cell plus a registered carry. It loads two operands on a start pulse and feeds the cell one bit pair per cycle, LSB first. The cell's carry is fed back through a flip-flop, and each sum bit is shifted into a result register. It is the area-minimal alternative to the ripple adder, for slow datapaths that accept WIDTH-cycle latency.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock, single clock domain
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only when idle or in DONE cycle
a  input  WIDTH  operand A; captured when start is accepted
b  input  WIDTH  operand B; captured when start is accepted
cin  input  1  carry-in; captured when start is accepted
busy  output  1  high while a bit-serial addition is in progress
done  output  1  one-cycle pulse when sum/cout become valid
sum  output  WIDTH  registered result; holds until next completion
cout  output  1  registered carry-out; holds until next completion

Behaviour:
- Reset: synchronous, active-low. When rst_n=0 at a rising edge of clk: state<=IDLE, busy=0, done=0, sum=0, cout=0, shift registers, carry flop and bit counter cleared.
- Reset mid-operation aborts the addition with no done pulse.
- States: IDLE, RUN, DONE. Encoding lives in the package.
- IDLE: start=1 -> load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, res_sr<=0; go to RUN. Otherwise stay.
- RUN, each cycle:
  - the cell computes s = a_sr[0]^b_sr[0]^carry and c = majority(a_sr[0], b_sr[0], carry);
  - res_sr <= {s, res_sr[WIDTH-1:1]};
  - a_sr, b_sr shift right by 1 (zero fill);
  - carry <= c; cnt <= cnt+1.
- RUN exit: when cnt == WIDTH-1, sum <= {s, res_sr[WIDTH-1:1]} and cout <= c, then go to DONE.
- DONE: lasts exactly one cycle with done=1.
  - start=1 in DONE: accepted like IDLE (load, go to RUN).
  - start=0 in DONE: go to IDLE.
- busy = (state==RUN). done = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- Latency: start high in cycle 0 -> busy high cycles 1..WIDTH -> done high and sum/cout valid in cycle WIDTH+1.
- Throughput: one addition per WIDTH+1 cycles.
- start while busy is ignored, not queued. Operand changes during RUN have no effect.
- sum/cout change only at the RUN->DONE transition (and at reset). They hold their value indefinitely otherwise.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Wrap of sum is reported only via cout.
- Counter width: $clog2(WIDTH). The counter never exceeds WIDTH-1.

Decomposition:
- Package serial_adder_pkg: state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2), plus the counter-width function.
- Sub-module: one instance of the team's existing one-bit full-adder cell (Full_Adder, ports sum/carry/a/b/c). It is driven by a_sr[0], b_sr[0] and the carry flop.
- No other sub-modules.

Test Plan:
1. WIDTH=8, a=0x3C, b=0x5A, cin=0, start pulse in cycle 0 -> busy cycles 1-8; done only in cycle 9; sum=0x96, cout=0.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
3. a=0x01, b=0x01 start cycle 0; start again cycle 3 with a=0x10, b=0x10 -> single done in cycle 9 with sum=0x02; second request ignored.
4. a=0xAA, b=0x55 start cycle 0; rst_n=0 in cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0; no done follows. Restarting with 0x0F+0x01 -> sum=0x10 nine cycles later.
5. Back-to-back: start held high through the DONE cycle of op 0x20+0x20 (sum=0x40) with new operands 0x80+0x80 -> second done 9 cycles after the first; sum=0x00, cout=1.
6. Randomised: 1000 random a/b/cin with random start gaps; scoreboard checks {cout,sum}=a+b+cin and done spacing >= WIDTH+1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and counter sizing.
// No logic here. Nothing in this file applies backpressure.
// Imported by serial_adder.
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit-counter width. Guarded so that a degenerate width still gets a 1-bit counter.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full-adder cell, purely combinational.
// Latency: 0 cycles. There is no handshake and no backpressure.
// Used as the single arithmetic cell of the bit-serial adder.
module Full_Adder (
    output logic sum,
    output logic carry,
    input  logic a,
    input  logic b,
    input  logic c
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, a registered carry, LSB first.
// Latency: start in cycle 0 gives done and a valid sum/cout in cycle WIDTH+1.
// Backpressure: a start is ignored while busy. A start in the DONE cycle is accepted.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             c;
    logic             accept;
    logic             last;

    Full_Adder u_fa (
        .sum   (s),
        .carry (c),
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c     (carry)
    );

    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last   = (state_q == ST_RUN) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last)  state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    // Operands are only captured on accept, so input changes during RUN are invisible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            carry  <= cin;
            cnt    <= '0;
        end else if (state_q == ST_RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {s, res_sr[WIDTH-1:1]};
            carry  <= c;
            cnt    <= cnt + CW'(1);
            if (last) begin
                sum  <= {s, res_sr[WIDTH-1:1]};
                cout <= c;
            end
        end
    end

endmodule
